multicycle_control: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode,

---
 rtl/multicycle_control.sv | 163 ++++++++++++++++
 tb/tb_multicycle_control.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback one state per clock and drives the 15-bit control word.
module multicycle_control #(
  parameter logic [2:0] ALU_ADD = 3'b010,
  parameter logic [2:0] ALU_SUB = 3'b110,
  parameter logic [2:0] ALU_AND = 3'b000,
  parameter logic [2:0] ALU_OR  = 3'b001,
  parameter logic [2:0] ALU_SLT = 3'b111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic [14:0] controls,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  state_e     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic [5:0] funct_q, funct_d;
  logic       funct_ok;
  logic [2:0] alu_sel;

  // Legality of the live funct, used while the instruction is still in DECODE.
  always_comb begin
    unique case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
      default:                               funct_ok = 1'b0;
    endcase
  end

  // EXECUTE sees only the captured funct, so a changing IR cannot disturb it.
  always_comb begin
    unique case (funct_q)
      FN_SUB:  alu_sel = ALU_SUB;
      FN_AND:  alu_sel = ALU_AND;
      FN_OR:   alu_sel = ALU_OR;
      FN_SLT:  alu_sel = ALU_SLT;
      default: alu_sel = ALU_ADD;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d  = S_FETCH;
    opcode_d = opcode_q;
    funct_d  = funct_q;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = opcode;
        funct_d  = funct;
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_ok ? S_EXECUTE : S_FETCH;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      funct_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
    end
  end

  always_comb begin
    controls   = '0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    unique case (state_q)
      S_FETCH:  controls = 15'h0851;
      S_DECODE: begin
        controls = 15'h00D0;
        unique case (opcode)
          OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
          OP_RTYPE: illegal = ~funct_ok;
          default:  illegal = 1'b1;
        endcase
      end
      S_MEMADR: controls = 15'h4090;
      S_MEMRD:  controls = 15'h0200;
      S_MEMWB: begin
        controls   = 15'h2100;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        controls   = 15'h0600;
        instr_done = 1'b1;
      end
      S_EXECUTE: controls = 15'h4000 | {9'b0, alu_sel, 3'b000};
      S_ALUWB: begin
        controls   = 15'h1100;
        instr_done = 1'b1;
      end
      // Branch target already sits in ALUOut; zero gates PCEn directly.
      S_BRANCH: begin
        controls   = 15'h4032 | {14'b0, zero};
        instr_done = 1'b1;
      end
      S_ADDIEXEC: controls = 15'h4090;
      S_ADDIWB: begin
        controls   = 15'h0100;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        controls   = 15'h0005;
        instr_done = 1'b1;
      end
      default: controls = '0;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic [14:0] controls;
  logic [3:0]  state;
  logic        instr_done;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [14:0] ctrl;
    logic        done;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .controls   (controls),
    .state      (state),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue the expectation for the current cycle, then advance to just after the next edge.
  task automatic step(input string tag, input logic [3:0] s, input logic [14:0] c,
                      input logic d, input logic il);
    exp_t e;
    e.tag  = tag;
    e.st   = s;
    e.ctrl = c;
    e.done = d;
    e.ill  = il;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check({mon_e.tag, ".state"},      32'(state),      32'(mon_e.st));
        check({mon_e.tag, ".controls"},   32'(controls),   32'(mon_e.ctrl));
        check({mon_e.tag, ".instr_done"}, 32'(instr_done), 32'(mon_e.done));
        check({mon_e.tag, ".illegal"},    32'(illegal),    32'(mon_e.ill));
      end
    end
  end

  logic [5:0]  rt_funct [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [14:0] rt_ctrl  [5] = '{15'h4010, 15'h4030, 15'h4000, 15'h4008, 15'h4038};

  initial begin
    reset  = 1'b0;
    opcode = 6'b0;
    funct  = 6'b0;
    zero   = 1'b0;

    // Reset asserted between clock edges must take effect at once.
    #2 reset = 1'b1;
    #1;
    check("rst_async.state",      32'(state),      32'd0);
    check("rst_async.controls",   32'(controls),   32'h0851);
    check("rst_async.instr_done", 32'(instr_done), 32'd0);
    check("rst_async.illegal",    32'(illegal),    32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // lw
    opcode = 6'b100011;
    step("lw.fetch",  4'd0, 15'h0851, 1'b0, 1'b0);
    step("lw.decode", 4'd1, 15'h00D0, 1'b0, 1'b0);
    step("lw.memadr", 4'd2, 15'h4090, 1'b0, 1'b0);
    step("lw.memrd",  4'd3, 15'h0200, 1'b0, 1'b0);
    step("lw.memwb",  4'd4, 15'h2100, 1'b1, 1'b0);

    // sw
    opcode = 6'b101011;
    step("sw.fetch",  4'd0, 15'h0851, 1'b0, 1'b0);
    step("sw.decode", 4'd1, 15'h00D0, 1'b0, 1'b0);
    step("sw.memadr", 4'd2, 15'h4090, 1'b0, 1'b0);
    step("sw.memwr",  4'd5, 15'h0600, 1'b1, 1'b0);

    // R-type: funct is scrambled during EXECUTE, controls must hold.
    for (int i = 0; i < 5; i++) begin
      opcode = 6'b000000;
      funct  = rt_funct[i];
      step($sformatf("rt%0d.fetch", i),  4'd0, 15'h0851, 1'b0, 1'b0);
      step($sformatf("rt%0d.decode", i), 4'd1, 15'h00D0, 1'b0, 1'b0);
      funct = 6'b000111;
      step($sformatf("rt%0d.execute", i), 4'd6, rt_ctrl[i], 1'b0, 1'b0);
      step($sformatf("rt%0d.aluwb", i),   4'd7, 15'h1100, 1'b1, 1'b0);
    end

    // addi
    opcode = 6'b001000;
    funct  = 6'b0;
    step("addi.fetch",  4'd0, 15'h0851, 1'b0, 1'b0);
    step("addi.decode", 4'd1, 15'h00D0, 1'b0, 1'b0);
    step("addi.exec",   4'd9, 15'h4090, 1'b0, 1'b0);
    step("addi.wb",     4'd10, 15'h0100, 1'b1, 1'b0);

    // beq taken, zero held high throughout
    opcode = 6'b000100;
    zero   = 1'b1;
    step("beq1.fetch",  4'd0, 15'h0851, 1'b0, 1'b0);
    step("beq1.decode", 4'd1, 15'h00D0, 1'b0, 1'b0);
    step("beq1.branch", 4'd8, 15'h4033, 1'b1, 1'b0);

    // beq not taken
    zero = 1'b0;
    step("beq0.fetch",  4'd0, 15'h0851, 1'b0, 1'b0);
    step("beq0.decode", 4'd1, 15'h00D0, 1'b0, 1'b0);
    step("beq0.branch", 4'd8, 15'h4032, 1'b1, 1'b0);

    // j
    opcode = 6'b000010;
    step("j.fetch",  4'd0, 15'h0851, 1'b0, 1'b0);
    step("j.decode", 4'd1, 15'h00D0, 1'b0, 1'b0);
    step("j.jump",   4'd11, 15'h0005, 1'b1, 1'b0);

    // Illegal opcode, then illegal R-type funct
    opcode = 6'b111111;
    step("ill_op.fetch",  4'd0, 15'h0851, 1'b0, 1'b0);
    step("ill_op.decode", 4'd1, 15'h00D0, 1'b0, 1'b1);
    opcode = 6'b000000;
    funct  = 6'b000111;
    step("ill_fn.fetch",  4'd0, 15'h0851, 1'b0, 1'b0);
    step("ill_fn.decode", 4'd1, 15'h00D0, 1'b0, 1'b1);

    // lw aborted by reset in MEMRD
    opcode = 6'b100011;
    funct  = 6'b0;
    step("lwr.fetch",  4'd0, 15'h0851, 1'b0, 1'b0);
    step("lwr.decode", 4'd1, 15'h00D0, 1'b0, 1'b0);
    step("lwr.memadr", 4'd2, 15'h4090, 1'b0, 1'b0);
    sb_q.push_back('{tag: "lwr.memrd", st: 4'd3, ctrl: 15'h0200, done: 1'b0, ill: 1'b0});
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("lwr_rst.state",      32'(state),      32'd0);
    check("lwr_rst.controls",   32'(controls),   32'h0851);
    check("lwr_rst.instr_done", 32'(instr_done), 32'd0);
    @(posedge clk);
    #1;
    check("lwr_hold.state",      32'(state),      32'd0);
    check("lwr_hold.instr_done", 32'(instr_done), 32'd0);
    reset = 1'b0;
    step("post.fetch",  4'd0, 15'h0851, 1'b0, 1'b0);
    step("post.decode", 4'd1, 15'h00D0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
